// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// 2-read / 1-write register file with an integrated per-register scoreboard.
// Decode reads operands and hazard status; writeback writes results and
// retires pending bits. All state updates on posedge CLK; RST_N is an
// asynchronous active-low clear of data, pending bits and PendCount.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a same-cycle write to ReadRegN is forwarded to ReadDataN, and
//               PendingN reports the post-edge pending state of that index.
//   undefined : reads return stored data; PendingN shows registered bits only.
//
// Ports
//   CLK, RST_N            clock / async active-low reset
//   ReadReg1/2            read indices
//   ReadData1/2           read data (combinational)
//   Pending1/2            read index has an outstanding write (combinational)
//   RegWrite/WriteReg/WriteData  write port; write also retires pending bit
//   IssueValid/IssueReg   producer issue, sets pending bit of IssueReg
//   PendCount             number of set pending bits (registered)
//   AnyPending            PendCount != 0
// -----------------------------------------------------------------------------
module reg_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Pending1,
  output logic              Pending2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueReg,
  output logic [ADDR_W:0]   PendCount,
  output logic              AnyPending
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr_en, iss_en, set_new, clr_new;

  // Effective write/issue: the hardwired zero register swallows both.
  always_comb begin
    wr_en  = RegWrite   && !(ZERO_REG && (WriteReg == '0));
    iss_en = IssueValid && !(ZERO_REG && (IssueReg == '0));
  end

  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_en) begin
      mem_d[WriteReg]  = WriteData;
      pend_d[WriteReg] = 1'b0;
    end
    // Issue applied after the retire so a same-index pair leaves the bit set.
    if (iss_en) begin
      pend_d[IssueReg] = 1'b1;
    end
    // Counter tracks only real 0->1 and 1->0 transitions of the pending bits.
    set_new = iss_en && !pend_q[IssueReg];
    clr_new = wr_en && pend_q[WriteReg] && !(iss_en && (IssueReg == WriteReg));
    cnt_d   = cnt_q + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_new);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic              rpend [2];

  always_comb begin
    raddr[0] = ReadReg1;
    raddr[1] = ReadReg2;
    for (int unsigned p = 0; p < 2; p++) begin
      rdata[p] = mem_q[raddr[p]];
      rpend[p] = pend_q[raddr[p]];
      if (ZERO_REG && (raddr[p] == '0)) begin
        rdata[p] = '0;
        rpend[p] = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      // RST_N gate keeps outputs at zero while reset is held.
      if (RST_N && wr_en && (WriteReg == raddr[p])) begin
        rdata[p] = WriteData;
        rpend[p] = iss_en && (IssueReg == raddr[p]);
      end
`endif
    end
  end

  always_comb begin
    ReadData1  = rdata[0];
    ReadData2  = rdata[1];
    Pending1   = rpend[0];
    Pending2   = rpend[1];
    PendCount  = cnt_q;
    AnyPending = (cnt_q != '0);
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [4:0]  ReadReg1 = '0, ReadReg2 = '0;
  logic [31:0] ReadData1, ReadData2;
  logic        Pending1, Pending2;
  logic        RegWrite = 1'b0;
  logic [4:0]  WriteReg = '0;
  logic [31:0] WriteData = '0;
  logic        IssueValid = 1'b0;
  logic [4:0]  IssueReg = '0;
  logic [5:0]  PendCount;
  logic        AnyPending;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Pending1(Pending1), .Pending2(Pending2),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .IssueValid(IssueValid), .IssueReg(IssueReg),
    .PendCount(PendCount), .AnyPending(AnyPending)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_p1;
    logic        e_p2;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs [15];
  vec_t sb [$];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One write/issue edge, then read back with write/issue idle.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge CLK);
    RegWrite = v.rw; WriteReg = v.wr; WriteData = v.wd;
    IssueValid = v.iv; IssueReg = v.ir;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    RegWrite = 1'b0; IssueValid = 1'b0;
    ReadReg1 = v.rr1; ReadReg2 = v.rr2;
    #1;
    if (sb.size() == 0) begin
      check($sformatf("sb_empty[%0d]", idx), 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check($sformatf("rd1[%0d]", idx), 64'(ReadData1), 64'(e.e_rd1));
      check($sformatf("rd2[%0d]", idx), 64'(ReadData2), 64'(e.e_rd2));
      check($sformatf("p1[%0d]", idx), 64'(Pending1), 64'(e.e_p1));
      check($sformatf("p2[%0d]", idx), 64'(Pending2), 64'(e.e_p2));
      check($sformatf("cnt[%0d]", idx), 64'(PendCount), 64'(e.e_cnt));
      check($sformatf("any[%0d]", idx), 64'(AnyPending), 64'(e.e_cnt != 0));
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                              input logic iv, input logic [4:0] ir,
                              input logic [4:0] rr1, input logic [4:0] rr2,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic p1, input logic p2, input logic [5:0] c);
    vec_t v;
    v.rw = rw; v.wr = wr; v.wd = wd; v.iv = iv; v.ir = ir;
    v.rr1 = rr1; v.rr2 = rr2; v.e_rd1 = e1; v.e_rd2 = e2;
    v.e_p1 = p1; v.e_p2 = p2; v.e_cnt = c;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  5, 0,  32'hDEADBEEF, 32'h0, 0, 0, 0);
    vecs[1]  = mk(1, 0,  32'h00001234, 1, 0,  0, 5,  32'h0, 32'hDEADBEEF, 0, 0, 0);
    vecs[2]  = mk(0, 0,  32'h0,        1, 3,  3, 7,  32'h0, 32'h0, 1, 0, 1);
    vecs[3]  = mk(0, 0,  32'h0,        1, 7,  3, 7,  32'h0, 32'h0, 1, 1, 2);
    vecs[4]  = mk(1, 3,  32'hAAAA0003, 0, 0,  3, 7,  32'hAAAA0003, 32'h0, 0, 1, 1);
    vecs[5]  = mk(1, 7,  32'h00000077, 0, 0,  7, 3,  32'h77, 32'hAAAA0003, 0, 0, 0);
    vecs[6]  = mk(0, 0,  32'h0,        1, 9,  9, 9,  32'h0, 32'h0, 1, 1, 1);
    vecs[7]  = mk(1, 9,  32'h00000055, 1, 9,  9, 9,  32'h55, 32'h55, 1, 1, 1);
    vecs[8]  = mk(1, 9,  32'h00000066, 1, 4,  4, 9,  32'h0, 32'h66, 1, 0, 1);
    vecs[9]  = mk(1, 12, 32'h00000012, 0, 0,  12, 4, 32'h12, 32'h0, 0, 1, 1);
    vecs[10] = mk(0, 0,  32'h0,        1, 4,  4, 4,  32'h0, 32'h0, 1, 1, 1);
    vecs[11] = mk(1, 4,  32'h00000044, 1, 4,  4, 4,  32'h44, 32'h44, 1, 1, 1);
    vecs[12] = mk(1, 4,  32'h00000045, 0, 0,  4, 5,  32'h45, 32'hDEADBEEF, 0, 0, 0);
    vecs[13] = mk(1, 10, 32'h0000000A, 1, 10, 10, 10, 32'hA, 32'hA, 1, 1, 1);
    vecs[14] = mk(1, 10, 32'h0000000B, 0, 0,  10, 9, 32'hB, 32'h66, 0, 0, 0);

    // Reset state
    ReadReg1 = 5'd5; ReadReg2 = 5'd31;
    #12;
    check("rst_rd1", 64'(ReadData1), 64'd0);
    check("rst_rd2", 64'(ReadData2), 64'd0);
    check("rst_cnt", 64'(PendCount), 64'd0);
    check("rst_any", 64'(AnyPending), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i], i);
    end

    // Same-cycle read while writing r5 (currently 0xDEADBEEF)
    @(negedge CLK);
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hCAFEF00D; ReadReg1 = 5'd5;
    #1;
    check("same_cycle_rd1", 64'(ReadData1), BYP ? 64'hCAFEF00D : 64'hDEADBEEF);
    @(posedge CLK); #1;
    RegWrite = 1'b0; #1;
    check("after_edge_rd1", 64'(ReadData1), 64'hCAFEF00D);

    // Same-cycle pending view: r8 pending, retired this cycle
    apply(mk(0, 0, 32'h0, 1, 8, 8, 0, 32'h0, 32'h0, 1, 0, 1), 100);
    @(negedge CLK);
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'h88; ReadReg1 = 5'd8;
    #1;
    check("same_cycle_p1_retire", 64'(Pending1), BYP ? 64'd0 : 64'd1);
    check("same_cycle_rd1_r8", 64'(ReadData1), BYP ? 64'h88 : 64'h0);
    @(posedge CLK); #1;
    RegWrite = 1'b0; #1;
    check("retire_r8_cnt", 64'(PendCount), 64'd0);

    // Retire and re-issue r8 together while not pending
    @(negedge CLK);
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'h89;
    IssueValid = 1'b1; IssueReg = 5'd8; ReadReg1 = 5'd8;
    #1;
    check("same_cycle_p1_reissue", 64'(Pending1), BYP ? 64'd1 : 64'd0);
    @(posedge CLK); #1;
    RegWrite = 1'b0; IssueValid = 1'b0; #1;
    check("reissue_r8_cnt", 64'(PendCount), 64'd1);
    apply(mk(1, 8, 32'h8A, 0, 0, 8, 0, 32'h8A, 32'h0, 0, 0, 0), 101);

    // Saturation: every nonzero register pending
    for (int r = 1; r < 32; r++) begin
      @(negedge CLK);
      IssueValid = 1'b1; IssueReg = 5'(r);
    end
    @(negedge CLK);
    IssueValid = 1'b0;
    check("sat_cnt", 64'(PendCount), 64'd31);
    apply(mk(0, 0, 32'h0, 1, 1, 1, 31, 32'h0, 32'h0, 1, 1, 31), 102);
    apply(mk(0, 0, 32'h0, 1, 0, 0, 30, 32'h0, 32'h0, 0, 1, 31), 103);

    // Mid-cycle asynchronous reset with live data and pending state
    @(negedge CLK);
    ReadReg1 = 5'd5; ReadReg2 = 5'd12;
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_rst_rd1", 64'(ReadData1), 64'd0);
    check("mid_rst_rd2", 64'(ReadData2), 64'd0);
    check("mid_rst_p1", 64'(Pending1), 64'd0);
    check("mid_rst_cnt", 64'(PendCount), 64'd0);
    check("mid_rst_any", 64'(AnyPending), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    // Retire after reset: data written, counter must not wrap
    apply(mk(1, 1, 32'h11, 0, 0, 1, 2, 32'h11, 32'h0, 0, 0, 0), 104);

    if (sb.size() != 0) check("sb_leftover", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
